// File: rtl/ewb_types.sv
// Shared definitions for the eviction write buffer.
//   DEFAULT_LINE_BITS : default cache line width in bits
//   OFFSET_BITS       : byte-offset bits within a line (fixed at 5)
//   ewb_state_t       : controller states
package ewb_types;

    localparam int DEFAULT_LINE_BITS = 256;
    localparam int OFFSET_BITS       = 5;
    localparam int TAG_BITS          = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        MEM_READ,
        DRAIN
    } ewb_state_t;

endpackage

// File: rtl/ewb_entry.sv
// Storage for the single buffered line: valid flag, line-aligned address and
// line data, plus the hit comparator used by the controller.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   load             : capture load_line/load_data and mark the entry valid
//   clear            : invalidate the entry (drain finished)
//   load_line        : line number (address bits 31:5) to capture
//   load_data        : line data to capture
//   lookup_line      : line number of the current cache request
//   valid            : entry holds a line
//   buf_addr         : buffered line address, offset bits always zero
//   buf_data         : buffered line data
//   hit              : valid and lookup_line matches the buffered line
module ewb_entry
    import ewb_types::*;
#(
    parameter int LINE_BITS = DEFAULT_LINE_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 clear,
    input  logic [TAG_BITS-1:0]  load_line,
    input  logic [LINE_BITS-1:0] load_data,
    input  logic [TAG_BITS-1:0]  lookup_line,
    output logic                 valid,
    output logic [31:0]          buf_addr,
    output logic [LINE_BITS-1:0] buf_data,
    output logic                 hit
);

    logic [TAG_BITS-1:0] line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            line_q   <= '0;
            buf_data <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            line_q   <= load_line;
            buf_data <= load_data;
        end else if (clear) begin
            valid    <= 1'b0;
        end
    end

    // Only the line number is stored; the offset is zero by construction.
    assign buf_addr = {line_q, {OFFSET_BITS{1'b0}}};
    assign hit      = valid && (lookup_line == line_q);

endmodule

// File: rtl/eviction_write_buffer.sv
// Single-entry eviction write buffer between the L1 memory port and physical
// memory. A dirty-line writeback is absorbed in one handshake; the line is
// written to memory once the bus has been idle for IDLE_CYCLES cycles, or
// earlier if a second writeback needs the entry. Reads that hit the buffered
// line are answered from the buffer.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cache_read/cache_write         : cache requests, held until cache_resp
//   cache_addr, cache_wdata        : request address / writeback line
//   cache_rdata, cache_resp        : registered read data, one-cycle ack
//   pmem_read/pmem_write           : memory requests, held until pmem_resp
//   pmem_addr, pmem_wdata          : registered line address / write line
//   pmem_rdata, pmem_resp          : memory read data / completion
module eviction_write_buffer
    import ewb_types::*;
#(
    parameter int LINE_BITS   = DEFAULT_LINE_BITS,
    parameter int IDLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cache_read,
    input  logic                 cache_write,
    input  logic [31:0]          cache_addr,
    input  logic [LINE_BITS-1:0] cache_wdata,
    output logic [LINE_BITS-1:0] cache_rdata,
    output logic                 cache_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_addr,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam logic [3:0] IDLE_LIMIT = 4'(IDLE_CYCLES);

    ewb_state_t state, next_state;
    logic [3:0] idle_cnt;

    logic                 valid;
    logic [31:0]          buf_addr;
    logic [LINE_BITS-1:0] buf_data;
    logic                 hit;

    logic entry_load;
    logic entry_clear;
    logic rdata_from_buf;
    logic rdata_from_mem;
    logic load_miss_addr;
    logic load_drain;

    logic [TAG_BITS-1:0] req_line;

    // Offset bits of the request address never matter to a line buffer.
    logic unused_offset;
    assign unused_offset = ^cache_addr[OFFSET_BITS-1:0];

    assign req_line = cache_addr[31:OFFSET_BITS];

    ewb_entry #(
        .LINE_BITS (LINE_BITS)
    ) u_entry (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (entry_load),
        .clear       (entry_clear),
        .load_line   (req_line),
        .load_data   (cache_wdata),
        .lookup_line (req_line),
        .valid       (valid),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .hit         (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A read takes priority over a write, which also makes a simultaneous
    // read+write behave as a read. A write that finds the entry full starts
    // a drain; it is accepted later from IDLE once the entry is free.
    always_comb begin
        next_state     = state;
        entry_load     = 1'b0;
        entry_clear    = 1'b0;
        rdata_from_buf = 1'b0;
        rdata_from_mem = 1'b0;
        load_miss_addr = 1'b0;
        load_drain     = 1'b0;
        case (state)
            IDLE: begin
                if (cache_read) begin
                    if (hit) begin
                        rdata_from_buf = 1'b1;
                        next_state     = RESP;
                    end else begin
                        load_miss_addr = 1'b1;
                        next_state     = MEM_READ;
                    end
                end else if (cache_write) begin
                    if (!valid) begin
                        entry_load = 1'b1;
                        next_state = RESP;
                    end else begin
                        load_drain = 1'b1;
                        next_state = DRAIN;
                    end
                end else if (valid && idle_cnt == IDLE_LIMIT) begin
                    load_drain = 1'b1;
                    next_state = DRAIN;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            MEM_READ: begin
                if (pmem_resp) begin
                    rdata_from_mem = 1'b1;
                    next_state     = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    entry_clear = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counts consecutive quiet IDLE cycles while a line is buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != IDLE || cache_read || cache_write || !valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LIMIT) begin
            idle_cnt <= idle_cnt + 4'd1;
        end
    end

    // Memory-side address/data are only loaded from IDLE, so they stay
    // stable for the whole of MEM_READ or DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_rdata <= '0;
            pmem_addr   <= '0;
            pmem_wdata  <= '0;
        end else begin
            if (rdata_from_buf) begin
                cache_rdata <= buf_data;
            end else if (rdata_from_mem) begin
                cache_rdata <= pmem_rdata;
            end
            if (load_miss_addr) begin
                pmem_addr <= {req_line, {OFFSET_BITS{1'b0}}};
            end else if (load_drain) begin
                pmem_addr  <= buf_addr;
                pmem_wdata <= buf_data;
            end
        end
    end

    assign cache_resp = (state == RESP);
    assign pmem_read  = (state == MEM_READ);
    assign pmem_write = (state == DRAIN);

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Self-checking bench for eviction_write_buffer (LINE_BITS=256, IDLE_CYCLES=2).
// A memory responder plays physical memory; a reference model tracks what the
// cache should read back for every line and which line the buffer holds.
module tb_eviction_write_buffer;

    localparam int LB = 256;
    localparam int K  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cache_read;
    logic          cache_write;
    logic [31:0]   cache_addr;
    logic [LB-1:0] cache_wdata;
    logic [LB-1:0] cache_rdata;
    logic          cache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_addr;
    logic [LB-1:0] pmem_wdata;
    logic [LB-1:0] pmem_rdata;
    logic          pmem_resp;

    eviction_write_buffer #(
        .LINE_BITS   (LB),
        .IDLE_CYCLES (K)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata),
        .cache_resp  (cache_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_addr   (pmem_addr),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: memory image, latest cache-visible line values and
    // the line currently expected in the buffer.
    logic [LB-1:0] mem_img [logic [26:0]];
    logic [LB-1:0] shadow  [logic [26:0]];
    bit            mdl_valid = 1'b0;
    logic [26:0]   mdl_line  = '0;
    logic [LB-1:0] mdl_data  = '0;

    // Memory responder controls and observations.
    bit          mem_stall       = 1'b0;
    int          mem_delay_fixed = -1;
    int          mem_wait;
    int          acc_start_cyc   = 0;
    logic [31:0] acc_addr;
    logic [LB-1:0] acc_wdata;
    int          read_done_cnt   = 0;
    int          last_rresp_cyc  = 0;
    int          last_wresp_cyc  = 0;
    logic [31:0] last_read_addr  = '0;

    // Current request bookkeeping.
    bit            req_write;
    logic [31:0]   req_addr;
    logic [LB-1:0] req_data;
    int            req_cyc;
    int            resp_cyc;
    int            reads_before;

    task automatic checkOutput(input string tag, input logic [LB-1:0] observed,
                               input logic [LB-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [LB-1:0] memValue(input logic [26:0] line);
        if (mem_img.exists(line)) return mem_img[line];
        return {8{{5'b0, line} ^ 32'h5A5A_C3C3}};
    endfunction

    function automatic logic [LB-1:0] shadowValue(input logic [26:0] line);
        if (shadow.exists(line)) return shadow[line];
        return memValue(line);
    endfunction

    function automatic logic [LB-1:0] randLine();
        logic [LB-1:0] d;
        for (int w = 0; w < LB / 32; w++) d[w*32 +: 32] = $urandom();
        return d;
    endfunction

    // A reset throws away the buffered line, so the cache sees memory again.
    task automatic resetModel();
        if (mdl_valid) shadow[mdl_line] = memValue(mdl_line);
        mdl_valid = 1'b0;
    endtask

    // Physical memory: answers each access after a delay, checks drains
    // against the model's buffered line and updates the memory image.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        mem_wait   = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pmem_resp = 1'b0;
                mem_wait  = -1;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                mem_wait  = -1;
            end else if (pmem_read || pmem_write) begin
                if (mem_wait < 0) begin
                    mem_wait      = (mem_delay_fixed >= 0) ? mem_delay_fixed : $urandom_range(0, 4);
                    acc_start_cyc = cyc;
                    acc_addr      = pmem_addr;
                    acc_wdata     = pmem_wdata;
                end
                if (!mem_stall) begin
                    if (mem_wait == 0) begin
                        pmem_resp = 1'b1;
                        checkOutput("pmem_addr_stable", pmem_addr, acc_addr);
                        checkOutput("pmem_addr_aligned", pmem_addr[4:0], 5'd0);
                        if (pmem_read) begin
                            pmem_rdata     = memValue(pmem_addr[31:5]);
                            last_read_addr = pmem_addr;
                            last_rresp_cyc = cyc;
                            read_done_cnt++;
                        end else begin
                            checkOutput("pmem_wdata_stable", pmem_wdata, acc_wdata);
                            checkOutput("drain_has_line", mdl_valid, 1'b1);
                            checkOutput("drain_addr", pmem_addr, {mdl_line, 5'b0});
                            checkOutput("drain_data", pmem_wdata, mdl_data);
                            mem_img[pmem_addr[31:5]] = pmem_wdata;
                            mdl_valid      = 1'b0;
                            last_wresp_cyc = cyc;
                        end
                    end else begin
                        mem_wait--;
                    end
                end
            end else begin
                mem_wait = -1;
            end
        end
    end

    task automatic startRequest(input bit is_write, input logic [31:0] addr,
                                input logic [LB-1:0] data);
        req_write    = is_write;
        req_addr     = addr;
        req_data     = data;
        cache_addr   = addr;
        cache_wdata  = data;
        cache_write  = is_write;
        cache_read   = !is_write;
        req_cyc      = cyc;
        reads_before = read_done_cnt;
    endtask

    // Waits for the ack, checks read data and whether memory was used, then
    // updates the model and confirms the ack lasted one cycle.
    task automatic finishRequest(output int latency, output bit used_mem);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!cache_resp && waited < 300);
        checkOutput("resp_seen", cache_resp, 1'b1);
        resp_cyc = cyc;
        latency  = resp_cyc - req_cyc;
        used_mem = (read_done_cnt != reads_before);
        if (cache_resp) begin
            if (req_write) begin
                shadow[req_addr[31:5]] = req_data;
                mdl_valid = 1'b1;
                mdl_line  = req_addr[31:5];
                mdl_data  = req_data;
            end else begin
                checkOutput("read_data", cache_rdata, shadowValue(req_addr[31:5]));
                checkOutput("read_used_mem", used_mem,
                            !(mdl_valid && mdl_line == req_addr[31:5]));
            end
        end
        cache_read  = 1'b0;
        cache_write = 1'b0;
        @(negedge clk);
        checkOutput("resp_one_cycle", cache_resp, 1'b0);
    endtask

    task automatic applyStimulus(input bit is_write, input logic [31:0] addr,
                                 input logic [LB-1:0] data,
                                 output int latency, output bit used_mem);
        startRequest(is_write, addr, data);
        finishRequest(latency, used_mem);
    endtask

    task automatic waitDrainStart();
        int n = 0;
        while (!pmem_write && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_started", pmem_write, 1'b1);
    endtask

    task automatic waitBufferEmpty();
        int n = 0;
        while (mdl_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("buffer_emptied", mdl_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            lat;
        bit            used;
        logic [LB-1:0] pat_a;
        logic [LB-1:0] pat_b;
        logic [LB-1:0] pat_c;
        logic [LB-1:0] pat_d;
        logic [31:0]   pool [4];

        pat_a = {32{8'hA5}};
        pat_b = {32{8'h3C}};
        pat_c = randLine();
        pat_d = randLine();
        pool  = '{32'h0000_1040, 32'h0000_2000, 32'h0000_3000, 32'h0000_4400};

        rst_n       = 1'b0;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_cache_resp", cache_resp, 1'b0);
        checkOutput("reset_pmem_read", pmem_read, 1'b0);
        checkOutput("reset_pmem_write", pmem_write, 1'b0);
        checkOutput("reset_pmem_addr", pmem_addr, 32'h0);
        checkOutput("reset_cache_rdata", cache_rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] write accept and opportunistic drain");
        applyStimulus(1'b1, 32'h0000_1044, pat_a, lat, used);
        checkOutput("write_accept_latency", lat, 1);
        for (int i = 0; i <= K + 1; i++) begin
            checkOutput("drain_timing", pmem_write, (i == K + 1));
            if (i < K + 1) @(negedge clk);
        end
        checkOutput("drain_pmem_addr", pmem_addr, 32'h0000_1040);
        checkOutput("drain_pmem_wdata", pmem_wdata, pat_a);
        waitBufferEmpty();

        $display("[TB] read hit from buffer");
        applyStimulus(1'b1, 32'h0000_1040, pat_b, lat, used);
        applyStimulus(1'b0, 32'h0000_105C, '0, lat, used);
        checkOutput("hit_latency", lat, 1);
        checkOutput("hit_no_pmem_read", used, 1'b0);

        $display("[TB] read miss with buffered line kept");
        mem_delay_fixed = 5;
        applyStimulus(1'b0, 32'h0000_2000, '0, lat, used);
        checkOutput("miss_pmem_addr", last_read_addr, 32'h0000_2000);
        checkOutput("miss_read_start", acc_start_cyc, req_cyc + 1);
        checkOutput("miss_mem_delay", last_rresp_cyc, acc_start_cyc + 5);
        checkOutput("miss_resp_at_M1", resp_cyc, last_rresp_cyc + 1);
        checkOutput("miss_keeps_valid", dut.u_entry.valid, 1'b1);

        $display("[TB] write while full");
        applyStimulus(1'b1, 32'h0000_3000, pat_d, lat, used);
        checkOutput("wfull_drain_start", acc_start_cyc, req_cyc + 1);
        checkOutput("wfull_resp_at_M2", resp_cyc, last_wresp_cyc + 2);
        checkOutput("wfull_valid", dut.u_entry.valid, 1'b1);
        checkOutput("wfull_buf_addr", dut.u_entry.buf_addr, 32'h0000_3000);
        mem_delay_fixed = -1;
        waitBufferEmpty();

        $display("[TB] read of a line that is draining");
        applyStimulus(1'b1, 32'h0000_1040, pat_c, lat, used);
        mem_stall = 1'b1;
        waitDrainStart();
        checkOutput("drain1040_addr", pmem_addr, 32'h0000_1040);
        startRequest(1'b0, 32'h0000_1040, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("wait_no_ack", cache_resp, 1'b0);
            checkOutput("wait_no_pmem_read", pmem_read, 1'b0);
        end
        mem_stall = 1'b0;
        finishRequest(lat, used);
        checkOutput("after_drain_miss", used, 1'b1);
        checkOutput("after_drain_addr", last_read_addr, 32'h0000_1040);

        $display("[TB] reset during drain");
        applyStimulus(1'b1, 32'h0000_1040, pat_d, lat, used);
        mem_stall = 1'b1;
        waitDrainStart();
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("rst_pmem_write", pmem_write, 1'b0);
        checkOutput("rst_cache_resp", cache_resp, 1'b0);
        checkOutput("rst_valid", dut.u_entry.valid, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 32'h0000_1040, '0, lat, used);
        checkOutput("post_reset_miss", used, 1'b1);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            applyStimulus($urandom_range(0, 1) == 1,
                          pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31)),
                          randLine(), lat, used);
        end
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eviction_write_buffer.md
# eviction_write_buffer

Single-entry eviction write buffer between the L1 cache's memory port and physical memory. It accepts a dirty-line writeback from the cache in one handshake and frees the cache to issue its miss read immediately. The buffered line drains to memory while the bus is otherwise idle. Reads that hit the buffered line are served from the buffer without a memory access.

## Interface
- `LINE_BITS`, default 256: cache line width; the line offset is log2(LINE_BITS/8) = 5 bits.
- `IDLE_CYCLES`, default 2, legal range 0..15: consecutive idle cycles required before an opportunistic drain starts.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cache_read`, in, 1: line read request; held until `cache_resp`.
- `cache_write`, in, 1: line writeback request; held until `cache_resp`.
- `cache_addr`, in, 32: byte address; offset bits are ignored.
- `cache_wdata`, in, LINE_BITS: writeback line.
- `cache_rdata`, out, LINE_BITS: registered read data; valid while `cache_resp`=1.
- `cache_resp`, out, 1: one-cycle completion pulse.
- `pmem_read`, out, 1: memory read, held until `pmem_resp`.
- `pmem_write`, out, 1: memory write, held until `pmem_resp`.
- `pmem_addr`, out, 32: registered, line-aligned (offset bits = 0).
- `pmem_wdata`, out, LINE_BITS: registered write line.
- `pmem_rdata`, in, LINE_BITS: sampled in the `pmem_resp` cycle.
- `pmem_resp`, in, 1: memory completion.

## Operation
- Storage: `valid`, `buf_addr` (32 bits, line-aligned) and `buf_data`.
- A hit is `valid && cache_addr[31:5] == buf_addr[31:5]`.
- States: IDLE, RESP, MEM_READ, DRAIN.
- IDLE, first matching rule wins:
  - `cache_read` && hit: latch `buf_data` into `cache_rdata`, then go to RESP.
  - `cache_read` && !hit: load `pmem_addr` with the aligned address, then go to MEM_READ.
  - `cache_write` && !valid: capture the aligned address and data, set `valid`, then go to RESP.
  - `cache_write` && valid: load `pmem_addr`/`pmem_wdata` from the buffer, then go to DRAIN. The write is accepted on the return to IDLE.
  - No request, `valid`, and idle count == IDLE_CYCLES: go to DRAIN.
- Simultaneous `cache_read` and `cache_write` is illegal; the block treats it as a read.
- Idle counter:
  - 4 bits.
  - Increments each IDLE cycle with no request and `valid`=1.
  - Clears on any request, outside IDLE, or when `valid`=0.
  - Saturates at IDLE_CYCLES.
- MEM_READ: `pmem_read`=1. On `pmem_resp`, latch `pmem_rdata` into `cache_rdata` and go to RESP.
- DRAIN:
  - `pmem_write`=1.
  - A drain is never aborted.
  - On `pmem_resp`, clear `valid` and go to IDLE.
  - Cache requests arriving during DRAIN wait and are not acknowledged.
- RESP: `cache_resp`=1 for exactly one cycle, then go to IDLE. The requester must drop or change its request in the following cycle.
- A read to the draining line waits for the drain to finish, then misses and is served from memory.

## Timing
- Reset values: state IDLE, `valid`=0, counter 0; all outputs 0. Reset takes effect immediately and asynchronously.
- Reset mid-operation drops `pmem_read`/`pmem_write` at once and discards the buffered line.
- Write accept (buffer empty): request seen in cycle N, `cache_resp` in cycle N+1.
- Read hit: `cache_resp` in cycle N+1, with data.
- Read miss: `pmem_read` rises in cycle N+1. With `pmem_resp` in cycle M, `cache_resp` and data appear in cycle M+1.
- Write while full: `pmem_write` from cycle N+1 until `pmem_resp` (cycle M); IDLE in M+1; `cache_resp` in M+2.
- Opportunistic drain: with IDLE_CYCLES=k, `pmem_write` rises k+1 cycles after the first idle cycle with `valid`=1. With k=0 it rises in the next cycle.
- `pmem_addr`/`pmem_wdata` are stable for the whole of each MEM_READ/DRAIN.

## Structure
- Shared package `ewb_types`: `LINE_BITS` default, `OFFSET_BITS`=5, and the `ewb_state_t` enum (IDLE, RESP, MEM_READ, DRAIN).
- Natural sub-module `ewb_entry`: `valid`/`buf_addr`/`buf_data` registers, the hit comparator, and load/clear controls.
- The FSM and idle counter live in `eviction_write_buffer`.

## Test plan
- Reset, then `cache_write` addr 0x0000_1044, data 0xA5 pattern -> `cache_resp` next cycle; after 3 idle cycles (k=2) `pmem_write` rises with `pmem_addr`=0x0000_1040 and data 0xA5 pattern.
- Buffer holds 0x1040; `cache_read` 0x0000_105C -> `cache_resp` next cycle with buffered data; `pmem_read` stays 0.
- Buffer holds 0x1040; `cache_read` 0x0000_2000 with `pmem_resp` after 5 cycles -> `pmem_addr`=0x2000; `cache_resp` one cycle after `pmem_resp` with `pmem_rdata`; buffer remains valid.
- Buffer full; `cache_write` 0x3000 -> DRAIN of 0x1040 completes, then new line accepted, `cache_resp` at M+2, `valid`=1 with `buf_addr`=0x3000.
- `cache_read` 0x1040 asserted during an in-progress drain of 0x1040 -> no ack until drain done, then `pmem_read` 0x1040, data from memory.
- Assert `rst_n`=0 while `pmem_write`=1 -> `pmem_write`, `cache_resp` and `valid` go to 0 immediately; after release, a read to 0x1040 misses to memory.
